// File: rtl/sp_wb8_target.sv
// ---------------------------------------------------------------------------
// sp_wb8_target
//
// Byte-wide Wishbone responder at the far end of the SP 32->8 bridge. Each
// 32-bit access arrives as four byte cycles on lanes 00..11 (big-endian,
// lane 00 = bits [0:7]). Write bytes are gathered in a staging word and
// committed to the register file atomically on lane 11. A read of lane 00
// snapshots the addressed word so that lanes 01..11 return a coherent word
// even if the host side rewrites it mid-access. A word-wide host port shares
// the same register file.
//
// Parameters
//   WORD_AW      word address width, register file holds 2**WORD_AW words
//   WAIT_STATES  extra cycles before each wb_ack_o (0..15)
//
// Configuration macro
//   WB8_TARGET_COMMIT_IRQ_EN  when defined, irq_o is a sticky commit
//                             interrupt cleared by irq_clr; otherwise irq_o
//                             is tied low and irq_clr is ignored.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   wb_adr_i [0:23]              byte address: [22:23] lane, word index above
//   wb_dat_i / wb_dat_o [0:7]    write byte / read byte (valid with ack)
//   wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_ack_o   Wishbone handshake
//   host_adr, host_we, host_wdata, host_rdata        host word port
//   commit_o, commit_adr_o       commit pulse and word index of last commit
//   collision_o                  host write lost to a same-word bus commit
//   irq_o, irq_clr               sticky commit interrupt and its clear
// ---------------------------------------------------------------------------
module sp_wb8_target #(
    parameter int WORD_AW     = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [0:23]        wb_adr_i,
    input  logic [0:7]         wb_dat_i,
    output logic [0:7]         wb_dat_o,
    input  logic               wb_we_i,
    input  logic [0:0]         wb_sel_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic               wb_ack_o,
    input  logic [WORD_AW-1:0] host_adr,
    input  logic               host_we,
    input  logic [0:31]        host_wdata,
    output logic [0:31]        host_rdata,
    output logic               commit_o,
    output logic [WORD_AW-1:0] commit_adr_o,
    output logic               collision_o,
    output logic               irq_o,
    input  logic               irq_clr
);

    localparam int         NWORDS  = 2 ** WORD_AW;
    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_cnt_next;
    logic       w_go;           // access completes at this edge (entering ACK)
    logic       w_req;

    // Address phase captured while IDLE
    logic [1:0]         r_lane;
    logic [WORD_AW-1:0] r_word;
    logic [0:7]         r_dat;
    logic               r_we;
    logic               r_sel;

    // Effective address phase: live bus while IDLE (zero-wait case completes
    // straight out of IDLE), captured copy once waiting.
    logic               w_in_idle;
    logic [1:0]         w_lane;
    logic [WORD_AW-1:0] w_word;
    logic [0:7]         w_dat;
    logic               w_we;
    logic               w_sel;

    logic               w_wr_go;
    logic               w_rd_go;
    logic               w_commit;

    logic [0:31]        r_stage;
    logic [0:3]         r_mask;
    logic [0:31]        w_stage_upd;
    logic [0:3]         w_mask_upd;

    logic [0:31]        w_regfile [NWORDS];
    logic [0:31]        w_live;
    logic [0:31]        w_rd_src;

    logic [0:31]        r_snap;
    logic               r_snap_valid;
    logic [WORD_AW-1:0] r_snap_tag;

    logic [0:7]         r_dat_o;
    logic               r_commit;
    logic [WORD_AW-1:0] r_commit_adr;
    logic               r_collision;

    assign w_req = wb_cyc_i & wb_stb_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_go            = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next = S_ACK;
                        w_go         = 1'b1;
                    end else begin
                        w_state_next    = S_WAIT;
                        w_wait_cnt_next = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                // Initiator abandoning the access returns us to IDLE silently.
                if (!w_req) begin
                    w_state_next = S_IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_state_next = S_ACK;
                    w_go         = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
            S_ACK:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        wb_ack_o = (r_state == S_ACK);
    end

    // ---------------- Address phase capture ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lane <= 2'd0;
            r_word <= '0;
            r_dat  <= '0;
            r_we   <= 1'b0;
            r_sel  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_lane <= wb_adr_i[22:23];
            r_word <= wb_adr_i[22-WORD_AW:21];
            r_dat  <= wb_dat_i;
            r_we   <= wb_we_i;
            r_sel  <= wb_sel_i[0];
        end
    end

    assign w_in_idle = (r_state == S_IDLE);
    assign w_lane    = w_in_idle ? wb_adr_i[22:23]          : r_lane;
    assign w_word    = w_in_idle ? wb_adr_i[22-WORD_AW:21]  : r_word;
    assign w_dat     = w_in_idle ? wb_dat_i                 : r_dat;
    assign w_we      = w_in_idle ? wb_we_i                  : r_we;
    assign w_sel     = w_in_idle ? wb_sel_i[0]              : r_sel;

    assign w_wr_go  = w_go & w_we;
    assign w_rd_go  = w_go & ~w_we;
    assign w_commit = w_wr_go & (w_lane == 2'd3);

    // ---------------- Write staging ----------------
    // Lane 00 opens a fresh word, so it starts from an empty mask.
    always_comb begin
        w_stage_upd = r_stage;
        w_stage_upd[{w_lane, 3'b000} +: 8] = w_dat;
        w_mask_upd = (w_lane == 2'd0) ? 4'b0000 : r_mask;
        w_mask_upd[w_lane] = w_sel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= '0;
            r_mask  <= '0;
        end else if (w_wr_go) begin
            r_stage <= w_stage_upd;
            r_mask  <= w_mask_upd;
        end else if (!wb_cyc_i) begin
            // Cycle ended without a lane-11 commit: discard the partial word.
            r_mask  <= '0;
        end
    end

    // ---------------- Register file ----------------
    // A bus commit to a word takes priority over a host write to that word.
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
        logic [0:31] r_word_q;
        logic        w_bus_hit;
        logic        w_host_hit;

        assign w_bus_hit  = w_commit && (w_word == WORD_AW'(gi));
        assign w_host_hit = host_we && (host_adr == WORD_AW'(gi));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_word_q <= '0;
            end else if (w_bus_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_mask_upd[b]) begin
                        r_word_q[8*b +: 8] <= w_stage_upd[8*b +: 8];
                    end
                end
            end else if (w_host_hit) begin
                r_word_q <= host_wdata;
            end
        end

        assign w_regfile[gi] = r_word_q;
    end

    assign w_live     = w_regfile[w_word];
    assign host_rdata = w_regfile[host_adr];

    // ---------------- Read path ----------------
    // Lane 00 always reads live and snapshots that same value; later lanes
    // use the snapshot only if it belongs to the word being read.
    assign w_rd_src = ((w_lane != 2'd0) && r_snap_valid && (r_snap_tag == w_word))
                      ? r_snap : w_live;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
            r_snap_tag   <= '0;
            r_dat_o      <= '0;
        end else begin
            if (w_rd_go && (w_lane == 2'd0)) begin
                r_snap       <= w_live;
                r_snap_valid <= 1'b1;
                r_snap_tag   <= w_word;
            end
            if (w_go) begin
                r_dat_o <= w_we ? 8'h00 : w_rd_src[{w_lane, 3'b000} +: 8];
            end
        end
    end

    // ---------------- Commit / collision flags ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_commit     <= 1'b0;
            r_commit_adr <= '0;
            r_collision  <= 1'b0;
        end else begin
            r_commit    <= w_commit;
            r_collision <= w_commit && host_we && (host_adr == w_word);
            if (w_commit) begin
                r_commit_adr <= w_word;
            end
        end
    end

    assign wb_dat_o     = r_dat_o;
    assign commit_o     = r_commit;
    assign commit_adr_o = r_commit_adr;
    assign collision_o  = r_collision;

    // ---------------- Optional commit interrupt ----------------
`ifdef WB8_TARGET_COMMIT_IRQ_EN
    logic r_irq;
    logic w_unused;

    // Set on the cycle after commit_o; a simultaneous clear loses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else if (r_commit) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_o    = r_irq;
    assign w_unused = ^wb_adr_i;
`else
    logic w_unused;

    assign irq_o    = 1'b0;
    assign w_unused = ^{wb_adr_i, irq_clr};
`endif

endmodule

// File: tb/tb_sp_wb8_target.sv
// ---------------------------------------------------------------------------
// tb_sp_wb8_target
//
// Two instances share one set of bus/host drivers: dut_a (WAIT_STATES=0) and
// dut_b (WAIT_STATES=3). dsel routes cyc/stb/host_we to one of them and
// selects whose outputs are observed. Expected values come from directed
// constants and a word-level register file model per instance.
// ---------------------------------------------------------------------------
module tb_sp_wb8_target;

    localparam int AW = 4;
`ifdef WB8_TARGET_COMMIT_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [0:23]   adr;
    logic [0:7]    wdat;
    logic          we;
    logic [0:0]    sel;
    logic          stb;
    logic          cyc;
    logic [AW-1:0] host_adr;
    logic          host_we;
    logic [0:31]   host_wdata;
    logic          irq_clr;
    int            dsel;

    logic          cyc_a, stb_a, hwe_a, cyc_b, stb_b, hwe_b;
    logic [0:7]    rdat_a, rdat_b, rdat;
    logic          ack_a, ack_b, ack;
    logic [0:31]   hrd_a, hrd_b, hrd;
    logic          commit_a, commit_b, commit;
    logic [AW-1:0] cadr_a, cadr_b, cadr;
    logic          coll_a, coll_b, coll;
    logic          irq_a, irq_b, irq;

    assign cyc_a  = cyc & (dsel == 0);
    assign stb_a  = stb & (dsel == 0);
    assign hwe_a  = host_we & (dsel == 0);
    assign cyc_b  = cyc & (dsel == 1);
    assign stb_b  = stb & (dsel == 1);
    assign hwe_b  = host_we & (dsel == 1);
    assign rdat   = (dsel == 1) ? rdat_b   : rdat_a;
    assign ack    = (dsel == 1) ? ack_b    : ack_a;
    assign hrd    = (dsel == 1) ? hrd_b    : hrd_a;
    assign commit = (dsel == 1) ? commit_b : commit_a;
    assign cadr   = (dsel == 1) ? cadr_b   : cadr_a;
    assign coll   = (dsel == 1) ? coll_b   : coll_a;
    assign irq    = (dsel == 1) ? irq_b    : irq_a;

    sp_wb8_target #(.WORD_AW(AW), .WAIT_STATES(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat_a),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb_a), .wb_cyc_i(cyc_a), .wb_ack_o(ack_a),
        .host_adr(host_adr), .host_we(hwe_a), .host_wdata(host_wdata), .host_rdata(hrd_a),
        .commit_o(commit_a), .commit_adr_o(cadr_a), .collision_o(coll_a),
        .irq_o(irq_a), .irq_clr(irq_clr)
    );

    sp_wb8_target #(.WORD_AW(AW), .WAIT_STATES(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat_b),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb_b), .wb_cyc_i(cyc_b), .wb_ack_o(ack_b),
        .host_adr(host_adr), .host_we(hwe_b), .host_wdata(host_wdata), .host_rdata(hrd_b),
        .commit_o(commit_b), .commit_adr_o(cadr_b), .collision_o(coll_b),
        .irq_o(irq_b), .irq_clr(irq_clr)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [2][16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_models();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                model[d][i] = 32'h0;
    endtask

    // Ignored upper address bits are randomised on purpose.
    function automatic logic [0:23] mk_adr(input logic [AW-1:0] w, input logic [1:0] l);
        logic [23:0] v;
        v = 24'($urandom() << (AW + 2)) | 24'({w, l});
        return v;
    endfunction

    // One byte cycle with cyc/stb held; optional host write lands on the
    // same clock edge that completes this byte.
    task automatic do_lane(input logic [1:0] l, input logic [AW-1:0] w, input logic wr,
                           input logic [7:0] d, input logic s, input int explat,
                           input logic hw, output logic [7:0] rd);
        int lat;
        adr = mk_adr(w, l);
        wdat = d;
        we = wr;
        sel[0] = s;
        cyc = 1'b1;
        stb = 1'b1;
        lat = 0;
        do begin
            host_we = hw && (lat == explat - 1);
            @(negedge clk);
            lat++;
        end while (!ack && lat < 40);
        host_we = 1'b0;
        chk($sformatf("ack_latency d%0d lane%0d", dsel, l), 32'(lat), 32'(explat));
        rd = rdat;
    endtask

    // Lanes first..last of one word; cycle ends after `last`.
    task automatic bus_word(input logic wr, input logic [AW-1:0] w, input logic [31:0] data,
                            input logic [0:3] s, input int first, input int last,
                            input int hlane, input logic [AW-1:0] ha, input logic [31:0] hd);
        logic [31:0] snap;
        logic [31:0] got;
        logic [7:0]  rd;
        logic        hw;
        logic        coll_exp;
        int          ws;
        ws = (dsel == 1) ? 3 : 0;
        snap = model[dsel][w];
        got = 32'h0;
        host_adr = ha;
        host_wdata = hd;
        for (int l = first; l <= last; l++) begin
            hw = (l == hlane);
            do_lane(2'(l), w, wr, data[31-8*l -: 8], s[l], (l == first) ? 1 + ws : 2 + ws, hw, rd);
            coll_exp = hw && wr && (l == 3) && (ha == w);
            if (hw && !coll_exp) model[dsel][ha] = hd;
            if (wr) begin
                chk($sformatf("commit d%0d lane%0d", dsel, l), 32'(commit), 32'(l == 3));
                if (l == 3) begin
                    chk($sformatf("commit_adr d%0d", dsel), 32'(cadr), 32'(w));
                    for (int k = first; k < 4; k++)
                        if (s[k]) model[dsel][w][31-8*k -: 8] = data[31-8*k -: 8];
                end
            end else begin
                got[31-8*l -: 8] = rd;
                chk($sformatf("rd_byte d%0d w%0d lane%0d", dsel, w, l), 32'(rd), 32'(snap[31-8*l -: 8]));
            end
            chk($sformatf("collision d%0d lane%0d", dsel, l), 32'(coll), 32'(coll_exp));
        end
        cyc = 1'b0;
        stb = 1'b0;
        @(negedge clk);
        chk("commit_one_pulse", 32'(commit), 32'h0);
        chk("collision_one_pulse", 32'(coll), 32'h0);
        if (wr && last == 3) chk("irq_after_commit", 32'(irq), 32'(IRQ_EN));
        $display("txn dut%0d %s word=%0d lanes=%0d..%0d data=%h sel=%b host_lane=%0d rdata=%h",
                 dsel, wr ? "WR" : "RD", w, first, last, data, s, hlane, got);
    endtask

    task automatic host_check(input logic [AW-1:0] a, input string tag);
        host_adr = a;
        #1;
        chk($sformatf("%s d%0d w%0d", tag, dsel, a), hrd, model[dsel][a]);
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, " ack"}, 32'(ack), 32'h0);
        chk({tag, " dat_o"}, 32'(rdat), 32'h0);
        chk({tag, " commit"}, 32'(commit), 32'h0);
        chk({tag, " commit_adr"}, 32'(cadr), 32'h0);
        chk({tag, " collision"}, 32'(coll), 32'h0);
        chk({tag, " irq"}, 32'(irq), 32'h0);
    endtask

    initial begin
        logic [AW-1:0] rw;
        logic          rwr;
        int            ack_seen;

        reset_n = 1'b0;
        adr = '0; wdat = '0; we = 1'b0; sel = '0; stb = 1'b0; cyc = 1'b0;
        host_adr = '0; host_we = 1'b0; host_wdata = '0; irq_clr = 1'b0;
        dsel = 0;
        clear_models();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state of both instances
        for (int d = 0; d < 2; d++) begin
            dsel = d;
            #1;
            idle_checks("reset");
            host_check(4'd3, "reset_regfile");
        end
        dsel = 0;

        // Full word write, all lanes enabled
        bus_word(1'b1, 4'd3, 32'h12345678, 4'b1111, 0, 3, -1, 4'd0, 32'h0);
        host_adr = 4'd3; #1;
        chk("t1 word3", hrd, 32'h12345678);

        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_cleared", 32'(irq), 32'h0);

        // Host write then bus read, host rewrites the word between lanes 01 and 10
        host_adr = 4'd5; host_wdata = 32'hAABBCCDD; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
        model[0][5] = 32'hAABBCCDD;
        bus_word(1'b0, 4'd5, 32'h0, 4'b0000, 0, 3, 2, 4'd5, 32'h0);
        host_adr = 4'd5; #1;
        chk("t2 host_overwrote", hrd, 32'h0);
        bus_word(1'b0, 4'd5, 32'h0, 4'b1111, 0, 3, -1, 4'd0, 32'h0);

        // Partial byte enables
        bus_word(1'b1, 4'd3, 32'hFFEEFFFF, 4'b1011, 0, 3, -1, 4'd0, 32'h0);
        host_adr = 4'd3; #1;
        chk("t3 word3", hrd, 32'hFF34FFFF);

        // Commit collides with host write to the same word, then a different word
        bus_word(1'b1, 4'd7, 32'h01020304, 4'b1111, 0, 3, 3, 4'd7, 32'hDEADBEEF);
        host_adr = 4'd7; #1;
        chk("t5 bus_wins", hrd, 32'h01020304);
        bus_word(1'b1, 4'd8, 32'hCAFEF00D, 4'b1111, 0, 3, 3, 4'd9, 32'h55AA55AA);
        host_adr = 4'd8; #1;
        chk("t5 bus_word8", hrd, 32'hCAFEF00D);
        host_adr = 4'd9; #1;
        chk("t5 host_word9", hrd, 32'h55AA55AA);

        // Randomised traffic against the model
        for (int i = 0; i < 24; i++) begin
            rwr = 1'($urandom_range(0, 1));
            rw  = 4'($urandom_range(0, 15));
            bus_word(rwr, rw, $urandom(), 4'($urandom_range(0, 15)), 0, 3,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1,
                     ($urandom_range(0, 3) == 0) ? rw : 4'($urandom_range(0, 15)), $urandom());
            host_check(4'($urandom_range(0, 15)), "rand_host");
        end

        // WAIT_STATES=3 instance: latency, abandoned cycle, mask clear on cyc drop
        dsel = 1;
        bus_word(1'b1, 4'd2, 32'h11223344, 4'b1111, 0, 3, -1, 4'd0, 32'h0);
        host_adr = 4'd2; #1;
        chk("t4 word2", hrd, 32'h11223344);
        bus_word(1'b1, 4'd2, 32'hA0A1A2A3, 4'b1111, 0, 1, -1, 4'd0, 32'h0);
        host_adr = 4'd2; #1;
        chk("t4 no_commit_on_drop", hrd, 32'h11223344);
        bus_word(1'b1, 4'd2, 32'hA0A1A2B3, 4'b1111, 3, 3, -1, 4'd0, 32'h0);
        host_adr = 4'd2; #1;
        chk("t4 lane3_only", hrd, 32'h112233B3);

        // Reset asserted while waiting
        adr = mk_adr(4'd4, 2'd0); wdat = 8'h5A; we = 1'b1; sel[0] = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6 ack_before_reset", 32'(ack), 32'h0);
        reset_n = 1'b0;
        #1;
        idle_checks("t6 in_reset");
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_models();
        ack_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack) ack_seen++;
        end
        chk("t6 no_ack_after_reset", 32'(ack_seen), 32'h0);
        host_check(4'd2, "t6 regfile_cleared");
        dsel = 0;
        host_check(4'd3, "t6 regfile_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
